sobel_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel edge pipeline. It sits between the camera luma stream and the Sobel ISP. It gates pixels into the ISP only inside a vsync-delimited frame and appends one dummy flush line so that the bottom image row leaves the 3x3 window. It also tags the ISP's delayed output with valid, x/y coordinates and a border flag, and double-buffers the edge threshold so it changes only at frame boundaries.

---
 rtl/sobel_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer and output tagger for the Sobel edge pipeline.
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   cam_vsync              frame sync level; a rising edge starts (or restarts) a frame
//   pix_valid, pix_Y       camera luma stream
//   thr_wr, thr_in         pending edge threshold write
//   isp_wr_en, isp_Y       gated pixel stream to the ISP, one dummy flush line appended
//   isp_thr                threshold frozen for the current frame
//   out_valid/x/y/border   tags aligned with the ISP result
//   frame_done, frame_err  end-of-frame and abnormal-event pulses
module sobel_frame_ctrl #(
   parameter int         H_ACT    = 640,
   parameter int         V_ACT    = 480,
   parameter int         PIPE_LAT = 5,
   parameter logic [7:0] THR_DEF  = 8'd27
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       cam_vsync,
   input  logic       pix_valid,
   input  logic [7:0] pix_Y,
   input  logic       thr_wr,
   input  logic [7:0] thr_in,
   output logic       isp_wr_en,
   output logic [7:0] isp_Y,
   output logic [7:0] isp_thr,
   output logic       out_valid,
   output logic [9:0] out_x,
   output logic [8:0] out_y,
   output logic       out_border,
   output logic       frame_done,
   output logic       frame_err
);
   localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
   localparam logic [8:0] Y_LAST = 9'(V_ACT - 1);
   localparam logic [8:0] Y_ROWS = 9'(V_ACT);
   localparam int         DW     = $clog2(PIPE_LAT + 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DRAIN} state_t;
   state_t state, state_nxt;

   logic                vs_d, vs_rise;
   logic [9:0]          in_x;
   logic [8:0]          in_y;
   logic [DW-1:0]       dr_cnt;
   logic                wr_nxt, err_nxt, done_nxt;
   logic [7:0]          y_nxt;
   logic [PIPE_LAT-1:0] dly;
   logic                d_en, tag;
   logic [9:0]          ox;
   logic [8:0]          orow;
   logic [7:0]          thr_pend;

   assign vs_rise = cam_vsync & ~vs_d;
   assign d_en    = dly[PIPE_LAT-1];
   // row 0 of the delayed stream is window fill and never tagged valid
   assign tag     = d_en & (orow != 9'd0);

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;

   // DRAIN holds one extra cycle so frame_done lands together with the last tagged output
   always_comb begin
      state_nxt = state;
      wr_nxt    = 1'b0;
      y_nxt     = 8'd0;
      err_nxt   = 1'b0;
      done_nxt  = 1'b0;
      if (vs_rise) begin
         state_nxt = ACTIVE;
         err_nxt   = state != IDLE;
      end else begin
         case (state)
            ACTIVE: if (pix_valid) begin
               wr_nxt    = 1'b1;
               y_nxt     = pix_Y;
               state_nxt = (in_x == X_LAST && in_y == Y_LAST) ? FLUSH : ACTIVE;
            end
            FLUSH: begin
               wr_nxt    = 1'b1;
               err_nxt   = pix_valid;
               state_nxt = (in_x == X_LAST) ? DRAIN : FLUSH;
            end
            DRAIN: if (dr_cnt == D_LAST) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
            default: ;
         endcase
      end
   end

   // in_x doubles as the flush-line counter: it is back at 0 when FLUSH starts
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vs_d       <= 1'b0;
         in_x       <= '0;
         in_y       <= '0;
         dr_cnt     <= '0;
         isp_wr_en  <= 1'b0;
         isp_Y      <= 8'd0;
         frame_err  <= 1'b0;
         frame_done <= 1'b0;
         isp_thr    <= THR_DEF;
         thr_pend   <= THR_DEF;
      end else begin
         vs_d       <= cam_vsync;
         isp_wr_en  <= wr_nxt;
         isp_Y      <= y_nxt;
         frame_err  <= err_nxt;
         frame_done <= done_nxt;
         dr_cnt     <= (state == DRAIN && !vs_rise) ? dr_cnt + 1'b1 : '0;
         thr_pend   <= thr_wr ? thr_in : thr_pend;
         if (vs_rise) begin
            isp_thr <= thr_wr ? thr_in : thr_pend;
            in_x    <= '0;
            in_y    <= '0;
         end else if (wr_nxt) begin
            in_x <= (in_x == X_LAST) ? '0 : in_x + 1'b1;
            if (state == ACTIVE && in_x == X_LAST) in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
         end
      end
   end

   // orow is the delayed-stream row: 0 = fill line, r = image row r-1
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dly        <= '0;
         ox         <= '0;
         orow       <= '0;
         out_valid  <= 1'b0;
         out_border <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
      end else if (vs_rise) begin
         dly        <= '0;
         ox         <= '0;
         orow       <= '0;
         out_valid  <= 1'b0;
         out_border <= 1'b0;
      end else begin
         dly        <= (dly << 1) | PIPE_LAT'(isp_wr_en);
         out_valid  <= tag;
         out_border <= tag & (ox == 10'd0 | ox == X_LAST | orow == 9'd1 | orow == Y_ROWS);
         if (tag) begin
            out_x <= ox;
            out_y <= orow - 9'd1;
         end
         if (d_en) begin
            ox <= (ox == X_LAST) ? '0 : ox + 1'b1;
            if (ox == X_LAST) orow <= (orow == Y_ROWS) ? '0 : orow + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: randomized bench with a cycle-indexed behavioural model of sobel_frame_ctrl.
module tb_sobel_frame_ctrl;
   localparam int H   = 8;
   localparam int V   = 4;
   localparam int P   = 5;
   localparam int N   = 8192;
   localparam int CLR = (V + 2) * H + P + 4;

   logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic       cam_vsync = 1'b0, pix_valid = 1'b0, thr_wr = 1'b0;
   logic [7:0] pix_Y = 8'd0, thr_in = 8'd0;
   logic       isp_wr_en, out_valid, out_border, frame_done, frame_err;
   logic [7:0] isp_Y, isp_thr;
   logic [9:0] out_x;
   logic [8:0] out_y;

   int checks = 0, failures = 0;

   sobel_frame_ctrl #(.H_ACT(H), .V_ACT(V), .PIPE_LAT(P), .THR_DEF(8'd27)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cam_vsync(cam_vsync),
      .pix_valid(pix_valid), .pix_Y(pix_Y), .thr_wr(thr_wr), .thr_in(thr_in),
      .isp_wr_en(isp_wr_en), .isp_Y(isp_Y), .isp_thr(isp_thr),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_border(out_border),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   // expectations indexed by the cycle that follows clock edge number t
   bit         e_wr[N];
   logic [7:0] e_y[N];
   bit         e_ov[N];
   int         e_x[N];
   int         e_row[N];
   bit         e_b[N];
   bit         e_done[N];
   bit         e_err[N];

   int t = 0, mst = 0, npix = 0, flush_last = 0, done_cyc = 0;
   int thr_m = 27, thr_p = 27;
   bit vs_prev = 1'b0;
   int n_wr, n_ov, n_bd, n_inner, n_done, n_err;
   int first_x, first_y, last_x, last_y;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, t, act, exp);
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = c; i < c + CLR && i < N; i++) begin
         e_wr[i] = 0; e_y[i] = 0; e_ov[i] = 0; e_x[i] = 0;
         e_row[i] = 0; e_b[i] = 0; e_done[i] = 0; e_err[i] = 0;
      end
   endtask

   // strobe s of a frame (pixels 0..V*H-1, then the flush line) yields tagged output s-H
   task automatic strobe(input int c, input logic [7:0] y, input int s);
      int oc;
      e_wr[c] = 1;
      e_y[c]  = y;
      if (s >= H) begin
         oc        = c + 1 + P;
         e_ov[oc]  = 1;
         e_x[oc]   = s % H;
         e_row[oc] = s / H - 1;
         e_b[oc]   = (e_x[oc] == 0) || (e_x[oc] == H - 1) || (e_row[oc] == 0) || (e_row[oc] == V - 1);
      end
   endtask

   task automatic model_step(input logic vs, input logic pv, input logic [7:0] py,
                             input logic tw, input logic [7:0] ti, input logic rn);
      bit vr, busy;
      if (!rn) begin
         clear_from(t);
         mst = 0; thr_m = 27; thr_p = 27; vs_prev = 0;
         return;
      end
      vr      = vs && !vs_prev;
      vs_prev = vs;
      busy    = (mst == 1) || (mst == 2 && t <= done_cyc);
      if (mst == 2 && t > done_cyc) mst = 0;
      if (vr) begin
         clear_from(t);
         e_err[t] = busy;
         thr_m    = tw ? int'(ti) : thr_p;
         mst      = 1;
         npix     = 0;
      end else if (mst == 1 && pv) begin
         strobe(t, py, npix);
         npix++;
         if (npix == V * H) begin
            for (int k = 0; k < H; k++) strobe(t + 1 + k, 8'd0, V * H + k);
            mst        = 2;
            flush_last = t + H;
            done_cyc   = t + H + 1 + P;
            e_done[done_cyc] = 1;
         end
      end else if (mst == 2 && pv && t <= flush_last) e_err[t] = 1;
      if (tw) thr_p = ti;
   endtask

   initial begin
      forever begin
         @(posedge sys_clk);
         t++;
         if (t + CLR >= N) begin
            $display("FAIL cycle_budget: edge %0d exceeds model window %0d", t, N);
            $fatal(1);
         end
         model_step(cam_vsync, pix_valid, pix_Y, thr_wr, thr_in, sys_rst_n);
         #1;
         if (!sys_rst_n) begin
            chk("rst_isp_wr_en", isp_wr_en, 0);
            chk("rst_isp_Y", isp_Y, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_x", out_x, 0);
            chk("rst_out_y", out_y, 0);
            chk("rst_out_border", out_border, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_isp_thr", isp_thr, 27);
         end else begin
            chk("isp_wr_en", isp_wr_en, e_wr[t]);
            if (e_wr[t]) chk("isp_Y", isp_Y, e_y[t]);
            chk("out_valid", out_valid, e_ov[t]);
            if (e_ov[t]) begin
               chk("out_x", out_x, e_x[t]);
               chk("out_y", out_y, e_row[t]);
            end
            chk("out_border", out_border, e_b[t]);
            chk("frame_done", frame_done, e_done[t]);
            chk("frame_err", frame_err, e_err[t]);
            chk("isp_thr", isp_thr, thr_m);
            if (isp_wr_en) n_wr++;
            if (out_border) n_bd++;
            if (frame_done) n_done++;
            if (frame_err) n_err++;
            if (out_valid) begin
               if (n_ov == 0) begin first_x = out_x; first_y = out_y; end
               last_x = out_x; last_y = out_y;
               n_ov++;
               if (out_border && out_x >= 1 && out_x <= 6 && out_y >= 1 && out_y <= 2) n_inner++;
            end
         end
      end
   end

   task automatic drive(input logic vs, input logic pv, input logic [7:0] y,
                        input logic tw, input logic [7:0] ti);
      @(negedge sys_clk);
      cam_vsync = vs; pix_valid = pv; pix_Y = y; thr_wr = tw; thr_in = ti;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic vs_start(input logic tw, input logic [7:0] ti);
      drive(1'b1, 1'b0, 8'($urandom), tw, ti);
   endtask

   // mode 0: back-to-back, 1: valid toggling 1/0, 2: random gaps with random threshold writes
   task automatic pixels(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         if (mode == 1 && i > 0) drive(1'b0, 1'b0, 8'($urandom), 1'b0, 8'd0);
         if (mode == 2)
            repeat ($urandom_range(0, 2))
               drive(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 5) == 0), 8'($urandom));
         drive(1'b0, 1'b1, 8'($urandom), 1'b0, 8'd0);
      end
   endtask

   task automatic clear_cnt();
      n_wr = 0; n_ov = 0; n_bd = 0; n_inner = 0; n_done = 0; n_err = 0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear_cnt();
      repeat (3) @(negedge sys_clk);
      chk("lit_reset_thr", isp_thr, 27);
      sys_rst_n = 1'b1;
      idle(3);

      clear_cnt();
      vs_start(1'b0, 8'd0); pixels(32, 0); idle(25);
      chk("lit_b2b_wr", n_wr, 40);
      chk("lit_b2b_ov", n_ov, 32);
      chk("lit_b2b_border", n_bd, 20);
      chk("lit_b2b_inner", n_inner, 0);
      chk("lit_b2b_done", n_done, 1);
      chk("lit_b2b_err", n_err, 0);
      chk("lit_b2b_first_x", first_x, 0);
      chk("lit_b2b_first_y", first_y, 0);
      chk("lit_b2b_last_x", last_x, 7);
      chk("lit_b2b_last_y", last_y, 3);

      clear_cnt();
      vs_start(1'b0, 8'd0); pixels(32, 1); idle(25);
      chk("lit_tog_wr", n_wr, 40);
      chk("lit_tog_ov", n_ov, 32);
      chk("lit_tog_border", n_bd, 20);
      chk("lit_tog_done", n_done, 1);
      chk("lit_tog_last_y", last_y, 3);

      vs_start(1'b0, 8'd0); pixels(10, 0);
      drive(1'b0, 1'b1, 8'($urandom), 1'b1, 8'd60);
      pixels(21, 0);
      chk("lit_thr_mid", isp_thr, 27);
      idle(25);
      chk("lit_thr_idle", isp_thr, 27);
      vs_start(1'b0, 8'd0); idle(1);
      chk("lit_thr_next", isp_thr, 60);
      pixels(32, 0); idle(25);
      vs_start(1'b1, 8'd90); idle(1);
      chk("lit_thr_same", isp_thr, 90);
      pixels(32, 0); idle(25);

      clear_cnt();
      vs_start(1'b0, 8'd0); pixels(13, 0);
      vs_start(1'b0, 8'd0); pixels(32, 0); idle(25);
      chk("lit_abort_err", n_err, 1);
      chk("lit_abort_ov", n_ov, 32);
      chk("lit_abort_done", n_done, 1);
      chk("lit_abort_wr", n_wr, 53);

      clear_cnt();
      vs_start(1'b0, 8'd0); pixels(35, 0); idle(25);
      chk("lit_flushpix_err", n_err, 3);
      chk("lit_flushpix_wr", n_wr, 40);
      chk("lit_flushpix_ov", n_ov, 32);

      vs_start(1'b0, 8'd0); pixels(10, 0);
      drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      sys_rst_n = 1'b0;
      idle(2);
      chk("lit_midrst_thr", isp_thr, 27);
      chk("lit_midrst_wr", isp_wr_en, 0);
      sys_rst_n = 1'b1;
      clear_cnt();
      pixels(8, 0); idle(10);
      chk("lit_midrst_nowr", n_wr, 0);
      chk("lit_midrst_nodone", n_done, 0);
      vs_start(1'b0, 8'd0); pixels(32, 0); idle(25);
      chk("lit_midrst_ov", n_ov, 32);

      for (int f = 0; f < 4; f++) begin
         clear_cnt();
         vs_start(1'($urandom_range(0, 1)), 8'($urandom));
         pixels(32, 2); idle(25);
         chk("lit_rand_ov", n_ov, 32);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
